// File: rtl/four_bit_up_counter_pkg.sv
// Shared definitions for four_bit_up_counter: mode encodings on sel and
// active-low seven-segment glyphs (bit order {g,f,e,d,c,b,a}).
package four_bit_up_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_CLR  = 2'b11
    } mode_t;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg_glyph(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/four_bit_up_counter_tick_prescaler.sv
// Slow-tick prescaler: divides clk by CLK_HZ/TICK_HZ and emits a registered
// one-cycle tick enable. restart returns the divider to phase 0.
module tick_prescaler #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk,
    input  logic Clear,
    input  logic restart,
    output logic tick
);

    localparam int unsigned PDIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CW   = (PDIV > 1) ? $clog2(PDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PDIV - 1);

    logic [CW-1:0] count;

    // Free-running divider; tick is high for the cycle after count hits LAST
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == LAST);
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/four_bit_up_counter.sv
// 4-bit up-counter digit with hold/count/load/clear modes, modulus wrap at
// MAX_COUNT and a registered cascade carry. Optional registered seven-segment
// output is enabled with macro FOUR_BIT_UP_SEG_EN.
module four_bit_up_counter
    import four_bit_up_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic       clk,
    input  logic       Clear,
    input  logic [1:0] sel,
    input  logic [3:0] load_val,
    input  logic       cin,
    output logic [3:0] Q,
    output logic       tick,
    output logic       cout
`ifdef FOUR_BIT_UP_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    localparam logic [3:0] MAX_Q = 4'(MAX_COUNT);

    mode_t      mode;
    logic       restart;
    logic [3:0] load_clamped;

    assign mode         = mode_t'(sel);
    assign restart      = (mode == MODE_LOAD) || (mode == MODE_CLR);
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .Clear  (Clear),
        .restart(restart),
        .tick   (tick)
    );

    // Count register and one-cycle carry; mode sampled on the same edge as tick
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            Q    <= '0;
            cout <= 1'b0;
        end else begin
            cout <= 1'b0;
            unique case (mode)
                MODE_HOLD: Q <= Q;
                MODE_UP: begin
                    if (tick && cin) begin
                        if (Q == MAX_Q) begin
                            Q    <= '0;
                            cout <= 1'b1;
                        end else begin
                            Q <= Q + 1'b1;
                        end
                    end
                end
                MODE_LOAD: Q <= load_clamped;
                MODE_CLR:  Q <= '0;
            endcase
        end
    end

`ifdef FOUR_BIT_UP_SEG_EN
    // Seven-segment code of Q, one cycle behind Q
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            seg <= SEG_0;
        end else begin
            seg <= seg_glyph(Q);
        end
    end
`endif

endmodule

// File: tb/tb_four_bit_up_counter.sv
// Bench for four_bit_up_counter: two digits (MAX_COUNT 15 and 9) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_four_bit_up_counter;

    localparam int PDIV = 8;

    logic       clk = 1'b0;
    logic       Clear = 1'b0;
    logic [1:0] sel = 2'b01;
    logic [3:0] load_val = 4'h0;
    logic       cin = 1'b1;

    logic [3:0] q15, q9;
    logic       tick15, tick9, cout15, cout9;
`ifdef FOUR_BIT_UP_SEG_EN
    logic [6:0] seg15, seg9;
`endif

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;
    int pulses15 = 0;
    int pulses9 = 0;

    always #5 clk = ~clk;

    four_bit_up_counter #(.CLK_HZ(8), .TICK_HZ(1), .MAX_COUNT(15)) dut15 (
        .clk(clk), .Clear(Clear), .sel(sel), .load_val(load_val), .cin(cin),
        .Q(q15), .tick(tick15), .cout(cout15)
`ifdef FOUR_BIT_UP_SEG_EN
        , .seg(seg15)
`endif
    );

    four_bit_up_counter #(.CLK_HZ(8), .TICK_HZ(1), .MAX_COUNT(9)) dut9 (
        .clk(clk), .Clear(Clear), .sel(sel), .load_val(load_val), .cin(cin),
        .Q(q9), .tick(tick9), .cout(cout9)
`ifdef FOUR_BIT_UP_SEG_EN
        , .seg(seg9)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tick fires whenever a positive multiple of PDIV edges
    // has elapsed since the last reset release or load/clear.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         maxv [2] = '{15, 9};
    int         m_q [2];
    logic       m_cout [2];
    logic [6:0] m_seg [2];
    int         m_since;
    logic       m_tick;

    always @(posedge clk or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < 2; i++) begin
                m_q[i]    <= 0;
                m_cout[i] <= 1'b0;
                m_seg[i]  <= 7'h40;
            end
            m_since <= 0;
            m_tick  <= 1'b0;
        end else begin
            automatic int ns;
            for (int i = 0; i < 2; i++) begin
                automatic int   nq = m_q[i];
                automatic logic nc = 1'b0;
                case (sel)
                    2'b01: if (m_tick && cin) begin
                        if (m_q[i] == maxv[i]) begin nq = 0; nc = 1'b1; end
                        else nq = m_q[i] + 1;
                    end
                    2'b10: nq = (int'(load_val) > maxv[i]) ? maxv[i] : int'(load_val);
                    2'b11: nq = 0;
                    default: ;
                endcase
                m_q[i]    <= nq;
                m_cout[i] <= nc;
                m_seg[i]  <= glyph_tab[m_q[i]];
            end
            ns = (sel[1]) ? 0 : m_since + 1;
            m_since <= ns;
            m_tick  <= (ns != 0) && (ns % PDIV == 0);
        end
    end

    // Per-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        if (run) begin
            check("q15", int'(q15), m_q[0]);
            check("q9", int'(q9), m_q[1]);
            check("tick15", int'(tick15), int'(m_tick));
            check("tick9", int'(tick9), int'(m_tick));
            check("cout15", int'(cout15), int'(m_cout[0]));
            check("cout9", int'(cout9), int'(m_cout[1]));
`ifdef FOUR_BIT_UP_SEG_EN
            check("seg15", int'(seg15), int'(m_seg[0]));
            check("seg9", int'(seg9), int'(m_seg[1]));
`endif
            if (cout15) pulses15++;
            if (cout9) pulses9++;
        end
    end

    task automatic async_clear();
        @(posedge clk);
        #2 Clear = 1'b1;
        #1;
        check("clr_q15", int'(q15), 0);
        check("clr_q9", int'(q9), 0);
        check("clr_tick", int'(tick15), 0);
        check("clr_cout", int'(cout15) + int'(cout9), 0);
        #4 Clear = 1'b0;
    endtask

    task automatic edges_until_tick(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!tick15 && n < 20);
    endtask

    initial begin
        int n;
        #1 Clear = 1'b1;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q15", int'(q15), 0);
        check("rst_tick", int'(tick15), 0);
        check("rst_cout", int'(cout15), 0);
`ifdef FOUR_BIT_UP_SEG_EN
        check("rst_seg", int'(seg15), 7'h40);
`endif
        Clear = 1'b0;

        // 20 increments: edges 9, 17, ..., 161 after release
        repeat (161) @(posedge clk);
        @(negedge clk); #1;
        check("count20_q15", int'(q15), 4);
        check("count20_q9", int'(q9), 0);
        check("wraps15", pulses15, 1);
        check("wraps9", pulses9, 2);

        // Clamped load, then next increment a full period later
        sel = 2'b10; load_val = 4'hC;
        @(posedge clk); #1;
        check("load_q9", int'(q9), 9);
        check("load_q15", int'(q15), 12);
        sel = 2'b01;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (q9 == 4'd9 && n < 20);
        check("load_gap", n, 9);
        check("load_wrap_q9", int'(q9), 0);
        check("load_wrap_cout9", int'(cout9), 1);

        // cin low freezes the count, then resumes
        cin = 1'b0;
        repeat (3 * PDIV + 2) @(posedge clk);
        #1 cin = 1'b1;
        repeat (2 * PDIV) @(posedge clk);
        #1;

        // Asynchronous clear mid-period at Q=7
        sel = 2'b10; load_val = 4'd7;
        @(posedge clk); #1;
        sel = 2'b00;
        repeat (3) @(posedge clk);
        #1 check("pre_clr_q15", int'(q15), 7);
        async_clear();
        sel = 2'b01;
        edges_until_tick(n);
        check("first_tick_gap", n, PDIV);

        // Synchronous clear at Q=5
        @(posedge clk); #1;
        sel = 2'b10; load_val = 4'd5;
        @(posedge clk); #1;
        sel = 2'b11;
        @(posedge clk); #1;
        check("sclr_q15", int'(q15), 0);
`ifdef FOUR_BIT_UP_SEG_EN
        check("seg_of_5", int'(seg15), 7'b0010010);
`endif
        sel = 2'b01;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (q15 == 4'd0 && n < 20);
        check("sclr_gap", n, PDIV + 1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            int r;
            @(posedge clk); #1;
            r = $urandom_range(0, 99);
            if (r < 2) async_clear();
            r = $urandom_range(0, 19);
            if (r < 14) sel = 2'b01;
            else if (r < 17) sel = 2'b00;
            else if (r < 19) sel = 2'b10;
            else sel = 2'b11;
            cin = ($urandom_range(0, 7) != 0);
            load_val = 4'($urandom);
        end

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
